// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game flow controller.
// Direction and game-state encodings are visible on the top-level ports.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int          CNT_W     = 5;
  localparam int          APPLE_W   = 8;
  localparam logic [3:0]  LEVEL_MAX = 4'd15;

  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      DIR_UP:   r = DIR_DOWN;
      DIR_DOWN: r = DIR_UP;
      DIR_LEFT: r = DIR_RIGHT;
      default:  r = DIR_LEFT;
    endcase
    return r;
  endfunction

  // max(init - lvl, min) without letting the subtraction wrap
  function automatic logic [4:0] calc_period(input logic [4:0] init_p,
                                             input logic [4:0] min_p,
                                             input logic [3:0] lvl);
    logic [4:0] lvl5;
    logic [4:0] diff;
    lvl5 = {1'b0, lvl};
    if (lvl5 >= init_p) diff = 5'd0;
    else                diff = init_p - lvl5;
    return (diff > min_p) ? diff : min_p;
  endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Frame strobe from the scan position, per-frame step counter and move_tick.
// The counter only advances while run is high and holds otherwise.
module snake_step_timer
  import snake_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  input  logic [31:0]      pxl_x,
  input  logic [31:0]      pxl_y,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             frame_pulse,
  output logic             move_tick
);

  logic             match;
  logic             match_q;
  logic [CNT_W-1:0] count;
  logic             terminal;

  assign match       = (pxl_x == 32'd0) && (pxl_y == 32'd0);
  assign frame_pulse = match & ~match_q;

  // >= rather than == so a period that shrinks mid-step cannot strand the count
  assign terminal  = ({1'b0, count} + 6'd1) >= {1'b0, period};
  assign move_tick = run & frame_pulse & terminal;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      match_q <= 1'b0;
      count   <= '0;
    end else begin
      match_q <= match;
      if (clear)                   count <= '0;
      else if (run && frame_pulse) count <= terminal ? '0 : count + 5'd1;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: state machine, step timing, heading and speed level.
// Define GAME_PAUSE_EN to build in the PAUSE state driven by the select button.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | game units held in reset, waiting for start
//   ST_PLAY  | snake steps every period frames
//   ST_PAUSE | timer and heading frozen (GAME_PAUSE_EN only)
//   ST_OVER  | collision seen, image frozen until start
module game_flow_ctrl
  import snake_pkg::*;
#(
  parameter int INIT_PERIOD      = 8,
  parameter int MIN_PERIOD       = 2,
  parameter int APPLES_PER_LEVEL = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] pxl_x,
  input  logic [31:0] pxl_y,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        start,
  input  logic        select,
  input  logic        endgame,
  input  logic        endgame_body,
  input  logic        apple_eaten,
  output logic        game_resetN,
  output logic        move_tick,
  output logic [1:0]  dir,
  output logic [1:0]  state,
  output logic [3:0]  level
);

  game_state_t        state_q, state_nxt;
  dir_t               dir_q, pend_q, joy_dir;
  logic               joy_valid;
  logic [3:0]         level_q;
  logic [APPLE_W-1:0] apple_cnt;
  logic               apple_lock;
  logic               start_q, apple_q;
  logic               start_edge, apple_edge, select_edge;
  logic               frame_pulse, run, clr, accept;
  logic [CNT_W-1:0]   period;

  assign start_edge = start & ~start_q;
  assign apple_edge = apple_eaten & ~apple_q;

`ifdef GAME_PAUSE_EN
  logic select_q;
  assign select_edge = select & ~select_q;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) select_q <= 1'b0;
    else         select_q <= select;
  end
`else
  logic unused_select;
  assign unused_select = select;
  assign select_edge   = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (start_edge) state_nxt = ST_PLAY;
      ST_PLAY: begin
        // collision outranks a same-cycle pause request
        if (endgame || endgame_body) state_nxt = ST_OVER;
        else if (select_edge)        state_nxt = ST_PAUSE;
      end
`ifdef GAME_PAUSE_EN
      ST_PAUSE: if (start_edge || select_edge) state_nxt = ST_PLAY;
`else
      ST_PAUSE: state_nxt = ST_IDLE;
`endif
      ST_OVER: if (start_edge) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign run    = (state_q == ST_PLAY);
  assign clr    = (state_nxt == ST_IDLE);
  assign period = calc_period(5'(INIT_PERIOD), 5'(MIN_PERIOD), level_q);

  snake_step_timer u_timer (
    .clk         (clk),
    .resetN      (resetN),
    .pxl_x       (pxl_x),
    .pxl_y       (pxl_y),
    .run         (run),
    .clear       (clr),
    .period      (period),
    .frame_pulse (frame_pulse),
    .move_tick   (move_tick)
  );

  always_comb begin
    joy_valid = 1'b1;
    joy_dir   = DIR_RIGHT;
    if (up)         joy_dir = DIR_UP;
    else if (down)  joy_dir = DIR_DOWN;
    else if (left)  joy_dir = DIR_LEFT;
    else if (right) joy_dir = DIR_RIGHT;
    else            joy_valid = 1'b0;
  end

  assign accept = run & apple_edge & ~apple_lock;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      game_resetN <= 1'b0;
      start_q     <= 1'b0;
      apple_q     <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      game_resetN <= (state_nxt != ST_IDLE);
      start_q     <= start;
      apple_q     <= apple_eaten;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dir_q  <= DIR_RIGHT;
      pend_q <= DIR_RIGHT;
    end else if (clr) begin
      dir_q  <= DIR_RIGHT;
      pend_q <= DIR_RIGHT;
    end else begin
      if (run && joy_valid && (joy_dir != opposite(dir_q))) pend_q <= joy_dir;
      if (move_tick) dir_q <= pend_q;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      apple_cnt  <= '0;
      apple_lock <= 1'b0;
      level_q    <= '0;
    end else if (clr) begin
      apple_cnt  <= '0;
      apple_lock <= 1'b0;
      level_q    <= '0;
    end else if (accept) begin
      apple_lock <= 1'b1;
      if (apple_cnt == APPLE_W'(APPLES_PER_LEVEL - 1)) begin
        apple_cnt <= '0;
        if (level_q != LEVEL_MAX) level_q <= level_q + 4'd1;
      end else begin
        apple_cnt <= apple_cnt + 1'b1;
      end
    end else if (frame_pulse) begin
      apple_lock <= 1'b0;
    end
  end

  assign dir   = dir_q;
  assign state = state_q;
  assign level = level_q;

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter INIT_PERIOD, default 8, frames per snake step at level 0.
REQ-002 SHALL have parameter MIN_PERIOD, default 2, fastest allowed frames per step.
REQ-003 SHALL have parameter APPLES_PER_LEVEL, default 4, apples eaten per speed-up.
REQ-004 SHALL have port clk input 1: the single 25 MHz pixel clock.
REQ-005 SHALL have port resetN input 1: asynchronous, active-low reset.
REQ-006 SHALL have ports pxl_x and pxl_y, input 32 each: current scan position.
REQ-007 SHALL have ports up, down, left and right, input 1 each: joystick levels.
REQ-008 SHALL have ports start and select, input 1 each: button levels.
REQ-009 SHALL have ports endgame and endgame_body, input 1 each: head-wall and head-body collision.
REQ-010 SHALL have port apple_eaten input 1: head/apple overlap level.
REQ-011 SHALL have port game_resetN output 1: active-low reset for the snake, body and apple units.
REQ-012 SHALL have port move_tick output 1: one-cycle step strobe.
REQ-013 SHALL have port dir output 2: committed heading, with UP=0, DOWN=1, LEFT=2, RIGHT=3.
REQ-014 SHALL have port state output 2: game state, with IDLE=0, PLAY=1, PAUSE=2, OVER=3.
REQ-015 SHALL have port level output 4: current speed level.

Function
REQ-016 frame_pulse SHALL be a one-cycle internal strobe on the first cycle pxl_x==0 && pxl_y==0 (registered rising edge of the match).
REQ-017 start, select and apple_eaten SHALL each be rising-edge detected through one register stage; only those edges act.
REQ-018 FSM: IDLE->PLAY on start edge; PLAY->OVER on endgame|endgame_body; PLAY->PAUSE on select edge; PAUSE->PLAY on start or select edge; OVER->IDLE on start edge.
REQ-019 Same-cycle collision and select edge in PLAY SHALL go to OVER.
REQ-020 game_resetN SHALL be registered: 0 in IDLE, 1 in PLAY, PAUSE and OVER, so the final image is frozen in OVER.
REQ-021 The frame counter SHALL clear on entry to PLAY, count frame_pulse only in PLAY, and hold in PAUSE and OVER.
REQ-022 move_tick SHALL assert for exactly one cycle, on the frame_pulse cycle where count==period-1; the counter then wraps to 0.
REQ-023 Joystick priority SHALL be up>down>left>right; the selected direction latches into pending_dir in PLAY only.
REQ-024 A pending direction that is the reverse of the committed dir SHALL be discarded.
REQ-025 dir SHALL update from pending_dir only on move_tick, giving at most one turn per step.
REQ-026 An apple edge in PLAY SHALL increment apple_cnt at most once per frame; a second edge before the next frame_pulse is ignored.
REQ-027 When apple_cnt reaches APPLES_PER_LEVEL it SHALL clear and level SHALL increment, saturating at 15.
REQ-028 period SHALL equal max(INIT_PERIOD-level, MIN_PERIOD), computed on 5-bit unsigned values with no underflow.

Reset
REQ-029 On resetN low: state=IDLE, game_resetN=0, move_tick=0, dir=RIGHT, pending_dir=RIGHT, level=0, all counters and edge registers 0.
REQ-030 Entry to IDLE SHALL clear dir, pending_dir, level, apple_cnt and frame count to their reset values.

Configuration
REQ-031 With GAME_PAUSE_EN defined, PAUSE SHALL exist as in REQ-018.
REQ-032 Without GAME_PAUSE_EN, select SHALL be ignored, PAUSE SHALL be unreachable, and state never equals 2.

Structure
REQ-033 Package snake_pkg SHALL hold the dir_t and game_state_t enums and the encodings given in REQ-013 and REQ-014.
REQ-034 Sub-module snake_step_timer SHALL contain frame_pulse generation, the frame counter and move_tick.

Verification
REQ-035 Reset, then a start edge -> state=1 and game_resetN=1 one cycle later; with period 8, move_tick once every 8 frames.
REQ-036 In PLAY with dir=RIGHT, hold left then up within one step -> left discarded, dir=UP at the next move_tick only.
REQ-037 Eat 4 apples, each overlap spanning 20 cycles within one frame -> level=1, period=7; 28 apples total -> period saturates at 2.
REQ-038 Select edge and endgame asserted in the same PLAY cycle -> state=3, game_resetN stays 1, move_tick stops.
REQ-039 With GAME_PAUSE_EN: select -> PAUSE with counter held; select again -> PLAY with the remaining count preserved. Without the macro -> state stays 1.
REQ-040 resetN pulsed low mid-PLAY at level 3 -> all outputs at reset values asynchronously.
